// File: rtl/pe_result_collector_if.sv
// pe_result_collector_if: valid/ready result stream from the collector FIFO head to the
// C writeback stage. Each beat carries a PE total plus its (row, col) and error tags.
interface pe_result_collector_if #(
    parameter int unsigned ACCUM_WIDTH = 32,
    parameter int unsigned RW          = 2,
    parameter int unsigned CW          = 2
);
    logic                   valid;
    logic                   ready;
    logic [ACCUM_WIDTH-1:0] data;
    logic [RW-1:0]          row;
    logic [CW-1:0]          col;
    logic                   err;

    modport master (output valid, data, row, col, err, input ready);
    modport slave  (input valid, data, row, col, err, output ready);
endinterface

// File: rtl/pe_result_collector.sv
// pe_result_collector: steps one PE through every (row, col) dot product of a C-matrix job,
// tags each result with its index and buffers it in a show-ahead FIFO for writeback.
// Issue is gated on free FIFO space, so a finished result always has a slot waiting.
// Optional feature macro: PE_RESULT_COLLECTOR_ERR_HALT_EN -- when defined, an errored result
// is still delivered but the job stops issuing and drains immediately afterwards.
module pe_result_collector #(
    parameter int unsigned ROWS        = 4,
    parameter int unsigned COLS        = 4,
    parameter int unsigned ACCUM_WIDTH = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned RW          = (ROWS <= 1) ? 1 : $clog2(ROWS),
    parameter int unsigned CW          = (COLS <= 1) ? 1 : $clog2(COLS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          job_go,
    output logic                          job_busy,
    output logic                          job_done,
    output logic                          job_err,
    output logic [RW-1:0]                 row_idx,
    output logic [CW-1:0]                 col_idx,
    output logic                          pe_start,
    output logic                          pe_load_row,
    input  logic                          pe_done,
    input  logic signed [ACCUM_WIDTH-1:0] pe_total,
    input  logic                          pe_err,
    pe_result_collector_if.master         out
);
    localparam int unsigned     PW       = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
    localparam int unsigned     CNTW     = $clog2(DEPTH + 1);
    localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(DEPTH);
    localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
    localparam logic [RW-1:0]   LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0]   LAST_COL = CW'(COLS - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDrain} state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          err_q, err_d;
    logic          done_q;

    logic          capture;
    logic          push;
    logic          pop;
    logic          last_entry;
    logic          halt;

    logic [ACCUM_WIDTH-1:0] mem_data [DEPTH];
    logic [RW-1:0]          mem_row  [DEPTH];
    logic [CW-1:0]          mem_col  [DEPTH];
    logic                   mem_err  [DEPTH];
    logic [PW-1:0]          wr_ptr_q;
    logic [PW-1:0]          rd_ptr_q;
    logic [CNTW-1:0]        count_q;

    // Only a fresh rising edge of the done level counts; a leftover level never captures.
    assign capture    = (state_q == StWait) && pe_done && !done_q;
    assign push       = capture;
    assign pop        = out.valid && out.ready;
    assign last_entry = (row_q == LAST_ROW) && (col_q == LAST_COL);

`ifdef PE_RESULT_COLLECTOR_ERR_HALT_EN
    assign halt = pe_err;
`else
    assign halt = 1'b0;
`endif

    assign job_busy  = (state_q != StIdle);
    assign job_err   = err_q;
    assign row_idx   = row_q;
    assign col_idx   = col_q;

    assign out.valid = (count_q != '0);
    assign out.data  = mem_data[rd_ptr_q];
    assign out.row   = mem_row[rd_ptr_q];
    assign out.col   = mem_col[rd_ptr_q];
    assign out.err   = mem_err[rd_ptr_q];

    // Job sequencing: next state, index advance, sticky error and PE control pulses.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        err_d       = err_q;
        pe_start    = 1'b0;
        pe_load_row = 1'b0;
        job_done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (job_go) begin
                    state_d = StIssue;
                    row_d   = '0;
                    col_d   = '0;
                    err_d   = 1'b0;
                end
            end
            StIssue: begin
                // At most one result is in flight, so one free slot is enough to issue.
                if (count_q < DEPTH_C) begin
                    pe_start    = 1'b1;
                    pe_load_row = (col_q == '0);
                    state_d     = StWait;
                end
            end
            StWait: begin
                if (capture) begin
                    err_d = err_q | pe_err;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    state_d = (last_entry || halt) ? StDrain : StIssue;
                end
            end
            StDrain: begin
                if (count_q == '0) begin
                    job_done = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state, indices, sticky error and the registered done level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            err_q   <= err_d;
            done_q  <= pe_done;
        end
    end

    // Result FIFO: circular buffer, tagged entries written at the current (row, col).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem_data[k] <= '0;
                mem_row[k]  <= '0;
                mem_col[k]  <= '0;
                mem_err[k]  <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr_q] <= pe_total;
                mem_row[wr_ptr_q]  <= row_q;
                mem_col[wr_ptr_q]  <= col_q;
                mem_err[wr_ptr_q]  <= pe_err;
                wr_ptr_q           <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pe_result_collector.sv
// Bench for pe_result_collector: behavioural PE, queue scoreboard and randomized jobs.
module tb_pe_result_collector;
    localparam int unsigned ROWS  = 2;
    localparam int unsigned COLS  = 2;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned RW    = 1;
    localparam int unsigned CW    = 1;
    localparam int unsigned NRES  = ROWS * COLS;

`ifdef PE_RESULT_COLLECTOR_ERR_HALT_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] data;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic          err;
    } res_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 job_go = 1'b0;
    logic                 job_busy, job_done, job_err;
    logic [RW-1:0]        row_idx;
    logic [CW-1:0]        col_idx;
    logic                 pe_start, pe_load_row;
    logic                 pe_done = 1'b0;
    logic signed [AW-1:0] pe_total = '0;
    logic                 pe_err = 1'b0;

    pe_result_collector_if #(.ACCUM_WIDTH(AW), .RW(RW), .CW(CW)) out_bus ();

    pe_result_collector #(
        .ROWS(ROWS), .COLS(COLS), .ACCUM_WIDTH(AW), .DEPTH(DEPTH), .RW(RW), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .job_go(job_go), .job_busy(job_busy), .job_done(job_done),
        .job_err(job_err), .row_idx(row_idx), .col_idx(col_idx), .pe_start(pe_start),
        .pe_load_row(pe_load_row), .pe_done(pe_done), .pe_total(pe_total), .pe_err(pe_err),
        .out(out_bus)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    int            start_total = 0;
    int            load_total = 0;
    int            done_total = 0;
    int            job_base = 0;
    int            load_base = 0;
    int            done_base = 0;
    int            exp_starts = 0;
    int            exp_loads = 0;
    logic          exp_job_err = 1'b0;
    logic [AW-1:0] cfg_salt = '0;
    int            cfg_lat = 2;
    int            cfg_hold = 0;
    logic [NRES-1:0] cfg_mask = '0;
    bit            rdy_rand = 1'b0;
    logic          rdy_force = 1'b0;
    res_t          exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // Expected results of a job straight from the job rules: row-major order, tagged by index.
    task automatic setup_job(input logic [AW-1:0] salt, input int lat, input int hold,
                             input logic [NRES-1:0] mask);
        res_t r;
        cfg_salt    = salt;
        cfg_lat     = lat;
        cfg_hold    = hold;
        cfg_mask    = mask;
        exp_starts  = 0;
        exp_loads   = 0;
        exp_job_err = 1'b0;
        for (int k = 0; k < int'(NRES); k++) begin
            r.data = salt + AW'(10 * (k / int'(COLS)) + k % int'(COLS));
            r.row  = RW'(k / int'(COLS));
            r.col  = CW'(k % int'(COLS));
            r.err  = mask[k];
            exp_q.push_back(r);
            exp_starts++;
            if (k % int'(COLS) == 0) exp_loads++;
            exp_job_err = exp_job_err | mask[k];
            if (HALT && mask[k]) break;
        end
        job_base  = start_total;
        load_base = load_total;
        done_base = done_total;
    endtask

    task automatic launch();
        job_go = 1'b1;
        step();
        job_go = 1'b0;
        check("go_to_start", pe_start, 1);
        check("busy_after_go", job_busy, 1);
        check("err_clear_on_go", job_err, 0);
        for (int h = 0; h < cfg_hold + 1 && cfg_hold > 0; h++) begin
            step();
            check("stale_done_no_capture", out_bus.valid, 0);
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (done_total == done_base && n < budget) begin
            step();
            n++;
        end
        check({name, "_done_seen"}, done_total - done_base, 1);
        step();
        check({name, "_busy_falls"}, job_busy, 0);
        check({name, "_done_pulse"}, job_done, 0);
        step();
        check({name, "_single_done"}, done_total - done_base, 1);
        check({name, "_starts"}, start_total - job_base, exp_starts);
        check({name, "_loads"}, load_total - load_base, exp_loads);
        check({name, "_all_delivered"}, exp_q.size(), 0);
    endtask

    // Ready driver: held by the main sequence or randomized per cycle.
    initial begin : ready_drv
        out_bus.ready = 1'b0;
        forever begin
            @(negedge clk);
            out_bus.ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    // Behavioural PE: done rises cfg_lat cycles after start, level held until after next start.
    initial begin : pe_model
        int cnt, hcnt, pi, pj, k;
        bit busy;
        cnt = 0; hcnt = 0; pi = 0; pj = 0; k = 0; busy = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                busy = 1'b0;
            end else if (pe_start) begin
                k = start_total - job_base;
                check("start_in_flight", busy, 0);
                check("start_allowed", k < exp_starts, 1);
                check("start_row", row_idx, k / int'(COLS));
                check("start_col", col_idx, k % int'(COLS));
                check("load_row", pe_load_row, (k % int'(COLS)) == 0);
                start_total++;
                if (pe_load_row) load_total++;
                pi = int'(row_idx);
                pj = int'(col_idx);
                busy = 1'b1;
                cnt = cfg_lat;
                hcnt = cfg_hold;
                if (hcnt == 0) pe_done = 1'b0;
            end else if (busy) begin
                check("idx_hold_row", row_idx, pi);
                check("idx_hold_col", col_idx, pj);
                if (hcnt > 0) begin
                    hcnt--;
                    if (hcnt == 0) pe_done = 1'b0;
                end else begin
                    cnt--;
                    if (cnt <= 0) begin
                        pe_done  = 1'b1;
                        pe_total = cfg_salt + AW'(10 * pi + pj);
                        pe_err   = cfg_mask[pi * int'(COLS) + pj];
                        busy     = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each accepted beat; checks stall stability and job end.
    initial begin : monitor
        res_t e;
        res_t held;
        bit   held_ok;
        held_ok = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                held_ok = 1'b0;
            end else begin
                if (held_ok && out_bus.valid) begin
                    check("stall_stable", {out_bus.data, out_bus.row, out_bus.col, out_bus.err},
                          held);
                end
                held_ok = 1'b0;
                if (out_bus.valid && out_bus.ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_output: got data %0d row %0d col %0d, required none",
                                 out_bus.data, out_bus.row, out_bus.col);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_bus.data, e.data);
                        check("out_row", out_bus.row, e.row);
                        check("out_col", out_bus.col, e.col);
                        check("out_err", out_bus.err, e.err);
                    end
                end else if (out_bus.valid) begin
                    held = {out_bus.data, out_bus.row, out_bus.col, out_bus.err};
                    held_ok = 1'b1;
                end
                if (job_done) begin
                    done_total++;
                    check("job_err_at_done", job_err, exp_job_err);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish within time limit");
        $fatal(1);
    end

    initial begin : main
        int n;
        step();
        step();
        check("rst_busy", job_busy, 0);
        check("rst_done", job_done, 0);
        check("rst_err", job_err, 0);
        check("rst_row_idx", row_idx, 0);
        check("rst_col_idx", col_idx, 0);
        check("rst_start", pe_start, 0);
        check("rst_load", pe_load_row, 0);
        check("rst_valid", out_bus.valid, 0);
        check("rst_data", out_bus.data, 0);
        check("rst_tags", {out_bus.row, out_bus.col, out_bus.err}, 0);
        rst_n = 1'b1;
        step();

        // Basic job: totals 10*i+j, consumer always ready.
        rdy_rand = 1'b0; rdy_force = 1'b1;
        setup_job('0, 5, 0, '0);
        launch();
        wait_done(300, "basic");

        // Stale done: level still high from the last job, held past the first start.
        setup_job(AW'($urandom), 3, 3, '0);
        launch();
        wait_done(300, "stale");

        // Backpressure: consumer stalled until the FIFO fills.
        rdy_force = 1'b0;
        setup_job(AW'($urandom), 3, 0, '0);
        launch();
        repeat (60) step();
        check("bp_starts_when_full", start_total - job_base, DEPTH);
        check("bp_valid_when_full", out_bus.valid, 1);
        check("bp_no_start_when_full", pe_start, 0);
        rdy_force = 1'b1;
        wait_done(300, "bp");

        // Error on the (0,1) result.
        setup_job(AW'($urandom), 4, 0, NRES'(2));
        launch();
        wait_done(300, "err01");

        // Reset in WAIT with one FIFO entry.
        rdy_force = 1'b0;
        setup_job(AW'($urandom), 4, 0, '0);
        launch();
        n = 0;
        while (start_total - job_base < 2 && n < 100) begin
            step();
            n++;
        end
        check("rst_mid_second_start", start_total - job_base, 2);
        step();
        check("rst_mid_one_entry", out_bus.valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", out_bus.valid, 0);
        check("rst_mid_busy", job_busy, 0);
        check("rst_mid_start", pe_start, 0);
        check("rst_mid_done", job_done, 0);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rst_mid_no_done", done_total - done_base, 0);
        rdy_force = 1'b1;
        setup_job(AW'($urandom), 3, 0, '0);
        launch();
        wait_done(300, "after_rst");

        // Randomized jobs with random ready, latency, hold and error masks.
        rdy_rand = 1'b1;
        for (int r = 0; r < 8; r++) begin
            setup_job(AW'($urandom), int'($urandom_range(2, 6)), int'($urandom_range(0, 2)),
                      NRES'($urandom_range(0, (1 << NRES) - 1)));
            launch();
            if (r % 2 == 1) begin
                job_go = 1'b1;
                step();
                job_go = 1'b0;
            end
            wait_done(600, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pe_result_collector.md
# pe_result_collector

- Sequences one PE through all `ROWS×COLS` dot products of a C-matrix job and captures each PE result into a show-ahead output FIFO.
- Tags every captured result with its `(row, col)` index.
- Sits directly downstream of the PE, and also drives the PE's `start`/`load_row` controls.
- Throttles issue so a finished result never finds the FIFO full; results leave over a valid/ready stream to the C writeback stage.

## Interface
- `ROWS`, 4: rows of C (A rows).
- `COLS`, 4: columns of C (B columns).
- `ACCUM_WIDTH`, 32: PE `total` width.
- `DEPTH`, 4: FIFO entries, ≥1.
- `RW`, `(ROWS<=1)?1:$clog2(ROWS)`: row index width.
- `CW`, `(COLS<=1)?1:$clog2(COLS)`: column index width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `job_go` in 1: start a job; honoured only in IDLE.
- `job_busy` out 1: high whenever state ≠ IDLE.
- `job_done` out 1: one-cycle pulse at job end.
- `job_err` out 1: sticky OR of captured errors; cleared on accepted `job_go`.
- `row_idx` out RW: current i; upstream selects A row i.
- `col_idx` out CW: current j; upstream selects B column j.
- `pe_start` out 1: one-cycle start pulse to the PE.
- `pe_load_row` out 1: pulses with `pe_start` when j==0.
- `pe_done` in 1: PE done level (rises at result valid, clears after next start).
- `pe_total` in ACCUM_WIDTH signed: PE result.
- `pe_err` in 1: PE overflow flag.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer accepts.
- `out_data` out ACCUM_WIDTH: head result.
- `out_row` out RW: head row tag.
- `out_col` out CW: head column tag.
- `out_err` out 1: head error tag.

## Operation
**States**
- IDLE: `job_go` → ISSUE. On that edge: i=j=0, `job_err`=0.
- ISSUE: if `count < DEPTH`, assert `pe_start` for one cycle, plus `pe_load_row` if j==0, then → WAIT. Otherwise hold, with no start.
- WAIT: on a rising edge of `pe_done`:
  - push `{pe_total, i, j, pe_err}`; `job_err |= pe_err`.
  - Advance j; when j==COLS-1, set j=0 and i++.
  - If the pushed entry was (ROWS-1, COLS-1), go to DRAIN; else go to ISSUE.
- DRAIN: when `count==0`, pulse `job_done` and go to IDLE.

**Completion detection**
- Rising edge means `pe_done & ~done_q`, where `done_q` is `pe_done` registered.
- A done level left over from the previous dot product never counts as a capture.

**FIFO**
- Circular buffer of `DEPTH` entries with its own read/write pointers and a 0..DEPTH count.
- Pop occurs on `out_valid & out_ready`.
- Push and pop in the same cycle leave `count` unchanged; both pointers advance and wrap modulo DEPTH.
- Outputs are read combinationally from the head entry.
- A push is never issued when full. The ISSUE gate guarantees this because at most one result is in flight.

**Other rules**
- `row_idx`/`col_idx` hold stable from `pe_start` until the capture.
- `job_go` outside IDLE is ignored.
- Index counters never exceed ROWS-1 / COLS-1.

## Timing
**Reset values**
- Every output is 0 during reset.
- FIFO is empty, state IDLE, i=j=0, `done_q`=0.
- Reset mid-job discards FIFO contents and any in-flight result. No `job_done` is produced.

**Latency**
- `job_go` → `pe_start`: 1 cycle.
- Capture edge → `out_valid` high: next cycle.
- Capture edge → next `pe_start`: next cycle. This gives a 2-cycle turnaround overhead per dot product beyond PE latency.
- Last capture with `out_ready` held high: `job_done` fires 2 cycles after the capture edge.

**Handshakes and stalls**
- `out_data`/tags are stable while `out_valid & ~out_ready`.
- `pe_start` stays low for as long as the FIFO is full.
- `job_busy` falls in the cycle after `job_done`.

## Configuration
- `PE_RESULT_COLLECTOR_ERR_HALT_EN` defined:
  - A capture with `pe_err`=1 is still pushed.
  - The block then goes to DRAIN regardless of index, so no further `pe_start` is issued.
  - `job_done` pulses once drained, with `job_err`=1.
- Not defined: the error is only tagged (`out_err`, `job_err`), and the job runs all ROWS×COLS products.

## Test plan
- Basic job:
  - Stimulus: ROWS=2, COLS=2, DEPTH=4, behavioural PE returning total=10·i+j after 5 cycles, `out_ready`=1.
  - Required: outputs (0,0,0), (0,1,1), (1,0,10), (1,1,11); `pe_load_row` on the 1st and 3rd starts only; one `job_done`; `job_err`=0.
- Backpressure:
  - Stimulus: DEPTH=2, `out_ready`=0 until four results are expected.
  - Required: exactly 2 `pe_start`s, `count`=2, no third start. After releasing `out_ready`, remaining results arrive in order with none lost or duplicated.
- Stale done level:
  - Stimulus: hold `pe_done`=1 continuously from the previous job when a new job starts.
  - Required: no capture until `pe_done` drops and rises again.
- Error, macro undefined:
  - Stimulus: `pe_err`=1 on the (0,1) result.
  - Required: `out_err`=1 for that entry only; all 4 results are delivered; `job_err`=1 at `job_done`.
- Error, macro defined:
  - Stimulus: same as above.
  - Required: only 2 results are delivered and no third `pe_start`; `job_done` fires with `job_err`=1.
- Reset mid-job:
  - Stimulus: assert `rst_n`=0 in WAIT with 1 FIFO entry.
  - Required: `out_valid`=0, `job_busy`=0, and `pe_start`=0 immediately. A following `job_go` restarts at (0,0).
